demux_sel_sequencer: RTL

//   Upstream driver for the 2-to-4 demux: accepts channel requests on a valid/ready handshake
//   and drives the demux select (A) and enable with glitch-safe timing.

---
 rtl/demux_pkg.sv | 16 +
 rtl/seq_down_counter.sv | 44 ++++
 rtl/demux_sel_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and defaults for the demux select sequencer
//
// Purpose : FSM state encoding and default widths used by demux_sel_sequencer.
// Ports   : none (package).
package demux_pkg;

    localparam int SEL_W_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_GUARD  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/seq_down_counter.sv
// rtl/seq_down_counter.sv - loadable down counter with an is-one flag
//
// Purpose : Holds the remaining dwell or guard cycles of the sequencer.
//           Load wins over decrement. The counter stops at zero.
// Ports   : clk      - rising-edge clock
//           reset    - synchronous active-high reset, clears the count
//           load     - load load_val on the next edge
//           load_val - value to load
//           dec      - decrement on the next edge (ignored at zero)
//           is_one   - count currently equals one
module seq_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         is_one
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_one = (cnt_q == W'(1));

endmodule

// File: rtl/demux_sel_sequencer.sv
// rtl/demux_sel_sequencer.sv - glitch-safe select/enable sequencer for a 2-to-4 demux
//
// Purpose : Accepts channel requests on a valid/ready handshake and drives the demux
//           select A and enable. Each request runs SETUP (A settles, enable low),
//           ACTIVE (enable high for the dwell) and GUARD (enable low), so A never
//           changes while enable is high.
// Config  : DEMUX_SEQ_AUTOSCAN_EN adds the auto_scan input, a scan pointer and the
//           AUTO_DWELL parameter; without it only external requests are issued.
// Ports   : clk       - rising-edge clock
//           reset     - synchronous active-high reset
//           req_valid - request present
//           req_ready - sequencer can accept (state is IDLE)
//           req_ch    - requested channel
//           req_dwell - enable-high cycles requested (0 treated as 1)
//           auto_scan - self-issue scan requests when idle (autoscan build only)
//           A         - registered demux select
//           enable    - registered demux enable
//           busy      - state is not IDLE
//           done      - one-cycle pulse after a request completes
import demux_pkg::*;

module demux_sel_sequencer #(
    parameter int SEL_W        = SEL_W_DEFAULT,
    parameter int DWELL_W      = 8,
    parameter int GUARD_CYCLES = 1
`ifdef DEMUX_SEQ_AUTOSCAN_EN
    ,
    parameter int AUTO_DWELL   = 4
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [SEL_W-1:0]   req_ch,
    input  logic [DWELL_W-1:0] req_dwell,
`ifdef DEMUX_SEQ_AUTOSCAN_EN
    input  logic               auto_scan,
`endif
    output logic [SEL_W-1:0]   A,
    output logic               enable,
    output logic               busy,
    output logic               done
);

    // A guard of 0 still needs a 1-bit counter instance; it is simply never used.
    localparam int GUARD_W = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);

    seq_state_e         state_q;
    logic [SEL_W-1:0]   a_q;
    logic               enable_q;
    logic               done_q;

    logic               issue_valid;
    logic [SEL_W-1:0]   issue_ch;
    logic [DWELL_W-1:0] issue_dwell;
    logic               accept;

    logic [DWELL_W-1:0] dwell_val;
    logic               dwell_load;
    logic               dwell_dec;
    logic               dwell_is_one;
    logic               guard_load;
    logic               guard_dec;
    logic               guard_is_one;

`ifdef DEMUX_SEQ_AUTOSCAN_EN
    localparam logic [DWELL_W-1:0] AUTO_DWELL_V = DWELL_W'(AUTO_DWELL);

    logic [SEL_W-1:0] scan_ptr_q;

    // External requests always win; the scan only fills otherwise idle slots.
    always_comb begin
        issue_valid = req_valid | auto_scan;
        issue_ch    = req_valid ? req_ch : scan_ptr_q;
        issue_dwell = req_valid ? req_dwell : AUTO_DWELL_V;
    end

    // Advance only when the scan itself was issued, so a pre-empting external
    // request leaves the scan position untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_ptr_q <= '0;
        end else if (accept && !req_valid) begin
            scan_ptr_q <= scan_ptr_q + SEL_W'(1);
        end
    end
`else
    always_comb begin
        issue_valid = req_valid;
        issue_ch    = req_ch;
        issue_dwell = req_dwell;
    end
`endif

    assign accept     = (state_q == ST_IDLE) && issue_valid;
    assign dwell_val  = (issue_dwell == '0) ? DWELL_W'(1) : issue_dwell;
    assign dwell_load = accept;
    assign dwell_dec  = (state_q == ST_ACTIVE);
    assign guard_load = (state_q == ST_ACTIVE) && dwell_is_one;
    assign guard_dec  = (state_q == ST_GUARD);

    seq_down_counter #(.W(DWELL_W)) u_dwell_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (dwell_load),
        .load_val (dwell_val),
        .dec      (dwell_dec),
        .is_one   (dwell_is_one)
    );

    seq_down_counter #(.W(GUARD_W)) u_guard_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (guard_load),
        .load_val (GUARD_W'(GUARD_CYCLES)),
        .dec      (guard_dec),
        .is_one   (guard_is_one)
    );

    // A only changes on the IDLE accept edge and enable only rises from SETUP,
    // so the select is always settled for a full cycle before enable goes high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue_valid) begin
                        a_q     <= issue_ch;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    enable_q <= 1'b1;
                    state_q  <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (dwell_is_one) begin
                        enable_q <= 1'b0;
                        if (GUARD_CYCLES == 0) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_GUARD;
                        end
                    end
                end
                ST_GUARD: begin
                    if (guard_is_one) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign A         = a_q;
    assign enable    = enable_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);
    assign req_ready = (state_q == ST_IDLE);

endmodule
